seg_scan_formatter: RTL and testbench

Display formatter and scan driver that sits directly downstream of the processor's output port. It captures the two 16-bit result words on a display strobe, converts each to four hex or decimal digits with a sequential binary-to-BCD engine, and holds an 8-digit image. It then time-multiplexes that image onto the shared 7-segment bus.

---
 rtl/seg_scan_pkg.sv | 51 +++++
 rtl/bin2bcd_seq.sv | 51 +++++
 rtl/seg_scan_formatter.sv | 149 ++++++++++++++
 tb/tb_seg_scan_formatter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and 7-segment glyph table for the display formatter/scan driver.
package seg_scan_pkg;

  typedef enum logic [1:0] {IDLE, CONV1, CONV2, COMMIT} state_t;

  localparam int unsigned NUM_DIGITS = 8;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high.
  localparam logic [7:0] GLYPH_0     = 8'h3F;
  localparam logic [7:0] GLYPH_1     = 8'h06;
  localparam logic [7:0] GLYPH_2     = 8'h5B;
  localparam logic [7:0] GLYPH_3     = 8'h4F;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'h6D;
  localparam logic [7:0] GLYPH_6     = 8'h7D;
  localparam logic [7:0] GLYPH_7     = 8'h07;
  localparam logic [7:0] GLYPH_8     = 8'h7F;
  localparam logic [7:0] GLYPH_9     = 8'h6F;
  localparam logic [7:0] GLYPH_A     = 8'h77;
  localparam logic [7:0] GLYPH_B     = 8'h7C;
  localparam logic [7:0] GLYPH_C     = 8'h39;
  localparam logic [7:0] GLYPH_D     = 8'h5E;
  localparam logic [7:0] GLYPH_E     = 8'h79;
  localparam logic [7:0] GLYPH_F     = 8'h71;
  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d, input logic blank);
    logic [7:0] g;
    unique case (d)
      4'h0: g = GLYPH_0;
      4'h1: g = GLYPH_1;
      4'h2: g = GLYPH_2;
      4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;
      4'h5: g = GLYPH_5;
      4'h6: g = GLYPH_6;
      4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;
      4'h9: g = GLYPH_9;
      4'hA: g = GLYPH_A;
      4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;
      4'hD: g = GLYPH_D;
      4'hE: g = GLYPH_E;
      4'hF: g = GLYPH_F;
    endcase
    return blank ? GLYPH_BLANK : g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// 16-bit sequential double-dabble: one shift-and-add-3 step per cycle.
module bin2bcd_seq (
  input  logic        use_clock,
  input  logic        n_reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [35:0] sr;
  logic [35:0] src;
  logic [35:0] nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_eff;
  logic        run;
  logic        active;

  // The first step is taken in the start cycle and the last step's result is
  // presented combinationally, so done lands on the 16th cycle after start.
  always_comb begin
    active  = start || run;
    src     = run ? sr : {20'd0, bin};
    cnt_eff = run ? cnt : 4'd0;
    nxt     = src;
    for (int unsigned i = 0; i < 5; i++) begin
      if (nxt[16 + 4*i +: 4] >= 4'd5) nxt[16 + 4*i +: 4] = nxt[16 + 4*i +: 4] + 4'd3;
    end
    nxt  = nxt << 1;
    done = active && (cnt_eff == 4'd15);
    bcd  = nxt[35:16];
  end

  always_ff @(posedge use_clock) begin
    if (!n_reset) begin
      sr  <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (active) begin
      sr <= nxt;
      if (done) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        run <= 1'b1;
        cnt <= cnt_eff + 4'd1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_formatter.sv
// Captures two 16-bit results, formats them as hex/decimal digits into an
// 8-digit image and time-multiplexes that image onto the 7-segment bus.
module seg_scan_formatter
  import seg_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 4096,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        use_clock,
  input  logic        n_reset,
  input  logic        outdisplay,
  input  logic [15:0] outval1,
  input  logic [15:0] outval2,
  input  logic [2:0]  outsel,
  output logic [7:0]  seg,
  output logic [7:0]  seg_sel,
  output logic        busy
);

  localparam int unsigned DIV_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [7:0]  SEG_POL = {8{SEG_ACTIVE_LOW}};

  state_t                      state;
  logic [15:0]                 val1, val2, pval1, pval2;
  logic [2:0]                  sel, psel;
  logic                        pend;
  logic [NUM_DIGITS*8-1:0]     img, disp;
  logic [DIV_W-1:0]            div;
  logic [2:0]                  idx;

  logic        eng_start, eng_done;
  logic [15:0] eng_bin;
  logic [19:0] eng_bcd;

  function automatic logic [31:0] format_half(input logic [15:0] d, input logic ov,
                                              input logic lz);
    logic [31:0] g;
    logic        blank;
    g     = '0;
    blank = lz && !ov;
    for (int unsigned k = 0; k < 4; k++) begin
      blank = blank && (d[(3-k)*4 +: 4] == 4'd0) && (k != 3);
      g[(3-k)*8 +: 8] = ov ? GLYPH_DASH : digit_glyph(d[(3-k)*4 +: 4], blank);
    end
    return g;
  endfunction

  always_comb begin
    eng_start = ((state == CONV1) && sel[0]) || ((state == CONV2) && sel[1]);
    eng_bin   = (state == CONV1) ? val1 : val2;
  end

  bin2bcd_seq u_bcd (
    .use_clock (use_clock),
    .n_reset   (n_reset),
    .start     (eng_start),
    .bin       (eng_bin),
    .done      (eng_done),
    .bcd       (eng_bcd)
  );

  always_ff @(posedge use_clock) begin
    if (!n_reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      pend  <= 1'b0;
      val1  <= '0;
      val2  <= '0;
      sel   <= '0;
      pval1 <= '0;
      pval2 <= '0;
      psel  <= '0;
      img   <= {NUM_DIGITS{GLYPH_BLANK}};
      disp  <= {NUM_DIGITS{GLYPH_BLANK}};
    end else begin
      unique case (state)
        IDLE: begin
          if (outdisplay) begin
            {val1, val2, sel} <= {outval1, outval2, outsel};
            state <= CONV1;
            busy  <= 1'b1;
          end else if (pend) begin
            {val1, val2, sel} <= {pval1, pval2, psel};
            pend  <= 1'b0;
            state <= CONV1;
            busy  <= 1'b1;
          end
        end
        CONV1: begin
          if (!sel[0]) begin
            img[63:32] <= format_half(val1, 1'b0, sel[2]);
            state      <= CONV2;
          end else if (eng_done) begin
            img[63:32] <= format_half(eng_bcd[15:0], eng_bcd[19:16] != 4'd0, sel[2]);
            state      <= CONV2;
          end
        end
        CONV2: begin
          if (!sel[1]) begin
            img[31:0] <= format_half(val2, 1'b0, sel[2]);
            state     <= COMMIT;
          end else if (eng_done) begin
            img[31:0] <= format_half(eng_bcd[15:0], eng_bcd[19:16] != 4'd0, sel[2]);
            state     <= COMMIT;
          end
        end
        COMMIT: begin
          disp <= img;
          // A strobe here is newer than any buffered one, so it is taken directly.
          if (outdisplay) begin
            {val1, val2, sel} <= {outval1, outval2, outsel};
            pend  <= 1'b0;
            state <= CONV1;
          end else if (pend) begin
            {val1, val2, sel} <= {pval1, pval2, psel};
            pend  <= 1'b0;
            state <= CONV1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
      if (outdisplay && ((state == CONV1) || (state == CONV2))) begin
        {pval1, pval2, psel} <= {outval1, outval2, outsel};
        pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge use_clock) begin
    if (!n_reset) begin
      div     <= '0;
      idx     <= '0;
      seg     <= GLYPH_BLANK ^ SEG_POL;
      seg_sel <= 8'h01;
    end else begin
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= idx + 3'd1;
      end else begin
        div <= div + 1'b1;
      end
      seg     <= disp[{idx, 3'b000} +: 8] ^ SEG_POL;
      seg_sel <= 8'h01 << idx;
    end
  end

endmodule

// File: tb/tb_seg_scan_formatter.sv
// Bench for seg_scan_formatter with SCAN_DIV=4: table of formatted images plus
// hand-written pending and mid-conversion reset sequences.
module tb_seg_scan_formatter;

  logic        use_clock  = 1'b0;
  logic        n_reset    = 1'b0;
  logic        outdisplay = 1'b0;
  logic [15:0] outval1    = '0;
  logic [15:0] outval2    = '0;
  logic [2:0]  outsel     = '0;
  logic [7:0]  seg, seg_sel;
  logic        busy;

  int          total = 0;
  int          bad   = 0;
  int unsigned n     = 0;
  logic [63:0] q[$];

  typedef struct {
    logic [15:0] v1;
    logic [15:0] v2;
    logic [2:0]  sel;
    logic [63:0] img;
  } vec_t;
  vec_t vecs[$];

  seg_scan_formatter #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
    .use_clock  (use_clock),
    .n_reset    (n_reset),
    .outdisplay (outdisplay),
    .outval1    (outval1),
    .outval2    (outval2),
    .outsel     (outsel),
    .seg        (seg),
    .seg_sel    (seg_sel),
    .busy       (busy)
  );

  always #5 use_clock = ~use_clock;

  // Edges taken out of reset; the expected scan position is derived from this.
  always @(posedge use_clock) begin
    if (!n_reset) n <= 0;
    else          n <= n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] glyph_of(input logic [7:0] c);
    case (c)
      "0": return 8'h3F;  "1": return 8'h06;  "2": return 8'h5B;  "3": return 8'h4F;
      "4": return 8'h66;  "5": return 8'h6D;  "6": return 8'h7D;  "7": return 8'h07;
      "8": return 8'h7F;  "9": return 8'h6F;  "A": return 8'h77;  "B": return 8'h7C;
      "C": return 8'h39;  "D": return 8'h5E;  "E": return 8'h79;  "F": return 8'h71;
      "-": return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s,
                         input logic [63:0] im);
    vec_t v;
    v.v1 = a; v.v2 = b; v.sel = s; v.img = im;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge; leaves the bench 1ns into the next cycle.
  task automatic strobe(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    outval1 = a; outval2 = b; outsel = s; outdisplay = 1'b1;
    @(posedge use_clock); #1;
    outdisplay = 1'b0;
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge use_clock);
      if (busy) cnt++;
      else break;
    end
  endtask

  // One full scan (8 digits x 4 cycles); each cycle is checked against the image.
  task automatic scan_check(input logic [63:0] im, input string name);
    int unsigned ix;
    logic [7:0]  es;
    @(negedge use_clock);
    for (int i = 0; i < 32; i++) begin
      @(negedge use_clock);
      ix = ((n - 1) / 4) % 8;
      es = 8'h01 << ix;
      chk({name, "_seg"}, {24'd0, seg}, {24'd0, glyph_of(im[ix*8 +: 8])});
      chk({name, "_sel"}, {24'd0, seg_sel}, {24'd0, es});
    end
  endtask

  initial begin
    int          cnt, lat, c;
    int unsigned ix;
    logic [63:0] img_a, img_b, img_c, front;

    add_vec(16'h12AB, 16'h00F0, 3'b000, "12AB00F0");
    add_vec(16'h04D2, 16'h270F, 3'b011, "12349999");
    add_vec(16'h2710, 16'h0007, 3'b111, "----   7");
    add_vec(16'h0000, 16'h0000, 3'b100, "   0   0");
    add_vec(16'h00A0, 16'h0105, 3'b100, "  A0 105");
    add_vec(16'hFFFF, 16'h0042, 3'b001, "----0042");
    add_vec(16'h0009, 16'h0000, 3'b110, "   9   0");
    add_vec(16'h270F, 16'h000A, 3'b111, "9999  10");
    add_vec(16'h8000, 16'h0100, 3'b011, "----0256");

    // Reset state and blank scan stepping.
    repeat (2) @(posedge use_clock);
    @(negedge use_clock);
    chk("rst_seg", {24'd0, seg}, 32'h00);
    chk("rst_sel", {24'd0, seg_sel}, 32'h01);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge use_clock); #1;
    n_reset = 1'b1;
    scan_check("        ", "rst_scan");
    @(posedge use_clock); #1;

    foreach (vecs[k]) begin
      strobe(vecs[k].v1, vecs[k].v2, vecs[k].sel);
      q.push_back(vecs[k].img);
      lat = (vecs[k].sel[0] ? 16 : 1) + (vecs[k].sel[1] ? 16 : 1) + 1;
      busy_len(cnt);
      chk($sformatf("v%0d_busy_len", k), cnt, lat);
      front = q.pop_front();
      scan_check(front, $sformatf("v%0d", k));
      @(posedge use_clock); #1;
    end

    // Pending: A decimal, B and C arrive during A; C replaces the buffered B.
    img_a = "11113333";
    img_b = "BEEF0001";
    img_c = " C0D  E0";
    strobe(16'h0457, 16'h0D05, 3'b011);
    q.push_back(img_a);
    cnt = 0;
    for (c = 1; c < 120; c++) begin
      if (c == 5) begin
        outval1 = 16'hBEEF; outval2 = 16'h0001; outsel = 3'b000; outdisplay = 1'b1;
        q.push_back(img_b);
      end else if (c == 10) begin
        outval1 = 16'h0C0D; outval2 = 16'h00E0; outsel = 3'b100; outdisplay = 1'b1;
        void'(q.pop_back());
        q.push_back(img_c);
      end else begin
        outdisplay = 1'b0;
      end
      @(negedge use_clock);
      if (c == 35) begin
        ix    = ((n - 1) / 4) % 8;
        front = q.pop_front();
        chk("pend_a_seg", {24'd0, seg}, {24'd0, glyph_of(front[ix*8 +: 8])});
      end
      if (busy) cnt++;
      else break;
      @(posedge use_clock); #1;
    end
    outdisplay = 1'b0;
    chk("pend_busy_len", cnt, 36);
    chk("pend_queue", q.size(), 1);
    front = q.pop_front();
    scan_check(front, "pend_c");
    @(posedge use_clock); #1;

    // Reset during a decimal conversion with a strobe buffered as pending.
    strobe(16'h270F, 16'h270F, 3'b011);
    q.push_back("99999999");
    @(posedge use_clock); #1;
    outval1 = 16'h1111; outval2 = 16'h2222; outsel = 3'b000; outdisplay = 1'b1;
    @(posedge use_clock); #1;
    outdisplay = 1'b0;
    repeat (5) @(posedge use_clock);
    #1;
    n_reset = 1'b0;
    q.delete();
    repeat (2) @(posedge use_clock);
    #1;
    n_reset = 1'b1;
    @(negedge use_clock);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge use_clock);
      if (busy) cnt++;
    end
    chk("midrst_no_commit", cnt, 0);
    scan_check("        ", "midrst_blank");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
